axil_cmd_master: RTL and testbench
==================================

# axil_cmd_master

AXI4-Lite master sequencer that turns a simple command stream into single-beat AXI4-Lite write, read and poll transactions. It is the initiator counterpart of the accelerator's AXI-Lite register slave: a test harness or on-chip controller drives `cmd_*`, and this block sets `matw`/`run`/`last` at 0x000, waits for `matw` to self-clear, and reads `control` at 0x010. One transaction is in flight at a time, and every command produces exactly one response.

## Interface
Parameters:
- `POLL_GAP`, default 4: idle cycles between successive poll reads.
- `POLL_MAX`, default 16'hFFFF: maximum number of reads in one poll command before it gives up with an error.

Ports:
- `M_AXI_ACLK`  in  1  The single clock.
- `M_AXI_ARESETN`  in  1  Reset, synchronous, active-low.
- `cmd_valid`, `cmd_ready`  in, out  1, 1  Command handshake.
- `cmd_op`  in  2  Operation: 00 write, 01 read, 10 poll, 11 reserved (treated as read).
- `cmd_addr`  in  32  Byte address. Bits [1:0] are ignored and driven as 0.
- `cmd_wdata`  in  32  Write data for a write; expected value for a poll.
- `cmd_mask`  in  32  Compare mask for a poll.
- `rsp_valid`, `rsp_ready`  out, in  1, 1  Response handshake.
- `rsp_rdata`  out  32  Last read data; 0 for a write.
- `rsp_err`  out  1  Any xRESP[1] seen, or poll limit hit.
- `rsp_polls`  out  16  Number of reads issued by a poll; 1 for a read; 0 for a write.
- `M_AXI_AWADDR/AWVALID/AWREADY`, `M_AXI_WDATA/WSTRB/WVALID/WREADY`, `M_AXI_BRESP/BVALID/BREADY`  Standard AXI4-Lite write channels. `WSTRB` is constant 4'hF.
- `M_AXI_ARADDR/ARVALID/ARREADY`, `M_AXI_RDATA/RRESP/RVALID/RREADY`  Standard AXI4-Lite read channels.

## Operation
- **States:** IDLE, WADDR, WRESP, RADDR, RDATA, GAP, RSP.
- **Command acceptance:** `cmd_ready` = (state==IDLE). On acceptance, the block latches op, addr, wdata and mask, clears the error and poll count, and moves to WADDR (write) or RADDR (read or poll).
- **WADDR:** `AWVALID` and `WVALID` both rise together.
  - Each channel drops independently on its own handshake, in either order, or both in the same cycle.
  - Once both channels are done, move to WRESP.
  - `AWADDR` and `WDATA` are stable while their VALID is high.
- **WRESP:** `BREADY`=1. On `BVALID`, set err |= BRESP[1] and move to RSP.
- **RADDR:** `ARVALID`=1 until `ARREADY`, then move to RDATA. The poll count increments on the AR handshake and saturates at 16'hFFFF.
- **RDATA:** `RREADY`=1. On `RVALID`, latch `RDATA` and set err |= RRESP[1].
  - Read: move to RSP.
  - Poll, match ((`RDATA` & mask) == (expected & mask)): move to RSP.
  - Poll, RRESP error: move to RSP with err=1. An error ends the poll immediately.
  - Poll, no match, count == `POLL_MAX`: move to RSP with err=1.
  - Poll, otherwise: move to GAP.
- **GAP:** count `POLL_GAP` cycles, then move to RADDR. With `POLL_GAP`=0, go directly to RADDR on the next cycle.
- **RSP:** `rsp_valid`=1 and the `rsp_*` outputs are held stable until `rsp_ready`, then move to IDLE.
- **Handshakes:** no VALID ever depends combinationally on the slave's READY. All AXI outputs and all `rsp_*` outputs are registered.
- **Reset values** (`M_AXI_ARESETN`=0 at a clock edge):
  - State IDLE.
  - All VALID and READY outputs 0; `cmd_ready` becomes 1 the cycle after reset is released.
  - `rsp_rdata`, `rsp_err`, `rsp_polls` = 0.
  - Address and data registers = 0.
- **Reset mid-operation:** all AXI VALID/READY signals drop at that edge and no response is produced. Recovering the slave is the system's responsibility; both ends share the same reset.

## Timing
- **Write, with the register slave** (slave takes AW+W together, then asserts BVALID the next cycle):
  - Cycle 0: command accepted.
  - Cycle 1: AW+W handshake.
  - Cycle 2: B handshake.
  - Cycle 3: `rsp_valid`=1.
  - Total: 3 cycles from acceptance to response.
- **Read, with the register slave** (ARREADY in INI, RVALID two cycles later):
  - Cycle 1: AR handshake.
  - Cycle 3: R handshake.
  - Cycle 4: `rsp_valid`=1.
- **Poll:** each unsuccessful read adds RADDR + RDATA + `POLL_GAP` + 1 cycles.
- **Back-to-back commands:** the earliest next `cmd_ready` is the cycle after the `rsp_valid`&`rsp_ready` handshake.
- **Independent AW/W:** with AWREADY delayed by N cycles and WREADY immediate, `WVALID` is high for exactly 1 cycle and `AWVALID` for N+1 cycles. WRESP is entered only after both handshakes complete.

## Test plan
- **Write:** write 0x000 ← 0x1 against the register slave → one AW and one W beat with AWADDR=0x0, WDATA=0x1, WSTRB=0xF; response rdata=0, err=0, polls=0; slave `matw`=1.
- **Poll:** poll 0x000, mask=0x1, expected=0x0, while `matw` self-clears after 100 cycles → response err=0, polls ≥ 2, (rdata & 1) = 0; consecutive ARs are spaced by ≥ `POLL_GAP`+2 cycles.
- **Split AW/W:** write with a slave model asserting WREADY at cycle 1 and AWREADY at cycle 5 → WVALID drops after cycle 1, AWVALID stays high through cycle 5, BREADY rises at cycle 6, exactly one response.
- **Error/limit:** read with RRESP=2'b10, RDATA=0xDEADBEEF → rsp_rdata=0xDEADBEEF, err=1, polls=1. Poll against a constant mismatch with `POLL_MAX`=3 → exactly 3 AR beats, err=1, polls=3.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles → rsp_* stable, `cmd_ready`=0 and no AXI VALID asserted throughout; the response is released on the first cycle with `rsp_ready`=1.
- **Reset mid-operation:** assert reset while ARVALID=1 and the slave is stalling → the next edge gives ARVALID=0, `rsp_valid`=0, all rsp_* zero; `cmd_ready`=1 the cycle after release; a subsequent read completes normally.

Source files
------------

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master sequencer: turns a command stream into single-beat write, read and poll
// transactions, one in flight at a time, with exactly one response per command.
module axil_cmd_master #(
    parameter int unsigned POLL_GAP = 4,
    parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cmd_mask,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] rsp_polls,

    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,

    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WADDR = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] RADDR = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;
    localparam logic [2:0] RSP   = 3'd6;

    localparam logic [1:0]  OP_WRITE = 2'b00;
    localparam logic [1:0]  OP_POLL  = 2'b10;
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP);

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mask_q, mask_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] gap_q, gap_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] rsp_polls_q, rsp_polls_d;

    logic is_poll;
    logic rd_match;
    logic at_limit;
    logic unused_bits;

    assign is_poll  = (op_q == OP_POLL);
    assign rd_match = ((M_AXI_RDATA & mask_q) == (wdata_q & mask_q));
    assign at_limit = (cnt_q == POLL_MAX);

    // Only the error bit of xRESP matters; the low address bits are forced to zero.
    assign unused_bits = ^{M_AXI_BRESP[0], M_AXI_RRESP[0], cmd_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_polls_d = rsp_polls_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = cmd_op;
                    addr_d      = {cmd_addr[31:2], 2'b00};
                    wdata_d     = cmd_wdata;
                    mask_d      = cmd_mask;
                    cnt_d       = 16'd0;
                    if (cmd_op == OP_WRITE) begin
                        state_d   = WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            WADDR: begin
                // AW and W retire independently; leave once both are gone.
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end

            WRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = M_AXI_BRESP[1];
                    rsp_polls_d = 16'd0;
                end
            end

            RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end
            end

            RDATA: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    if (!is_poll || rd_match || M_AXI_RRESP[1] || at_limit) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = M_AXI_RDATA;
                        rsp_err_d   = M_AXI_RRESP[1] | (is_poll & ~rd_match & at_limit);
                        rsp_polls_d = cnt_q;
                    end else begin
                        state_d = GAP;
                        gap_d   = 16'd0;
                    end
                end
            end

            GAP: begin
                // Lasts POLL_GAP+1 cycles, so a zero gap still spends one cycle here.
                if (gap_q == GAP_LAST) begin
                    state_d   = RADDR;
                    arvalid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            mask_q      <= 32'd0;
            cnt_q       <= 16'd0;
            gap_q       <= 16'd0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_polls_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_polls_q <= rsp_polls_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_polls     = rsp_polls_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a configurable register-slave model on the main instance
// and a trivial always-ready slave on a second instance built for the poll-limit case.
module tb_axil_cmd_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_wdata, cmd_mask, rsp_rdata;
    logic [15:0] rsp_polls;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    axil_cmd_master dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_polls(rsp_polls),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Second instance: zero gap, limit of 3 reads.
    logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [1:0]  b_cmd_op;
    logic [31:0] b_cmd_addr, b_cmd_wdata, b_cmd_mask, b_rsp_rdata;
    logic [15:0] b_rsp_polls;
    logic [31:0] b_awaddr, b_wdata, b_araddr;
    logic [3:0]  b_wstrb;
    logic        b_awvalid, b_wvalid, b_bready, b_arvalid, b_rvalid, b_rready;
    int          b_ar_beats;

    axil_cmd_master #(.POLL_GAP(0), .POLL_MAX(16'd3)) dut_lim (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
        .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata), .cmd_mask(b_cmd_mask),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .rsp_polls(b_rsp_polls),
        .M_AXI_AWADDR(b_awaddr), .M_AXI_AWVALID(b_awvalid), .M_AXI_AWREADY(1'b1),
        .M_AXI_WDATA(b_wdata), .M_AXI_WSTRB(b_wstrb), .M_AXI_WVALID(b_wvalid),
        .M_AXI_WREADY(1'b1), .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b0), .M_AXI_BREADY(b_bready),
        .M_AXI_ARADDR(b_araddr), .M_AXI_ARVALID(b_arvalid), .M_AXI_ARREADY(1'b1),
        .M_AXI_RDATA(32'd0), .M_AXI_RRESP(2'b00), .M_AXI_RVALID(b_rvalid),
        .M_AXI_RREADY(b_rready)
    );

    always @(posedge clk) begin
        if (!rst_n) begin
            b_rvalid   <= 1'b0;
            b_ar_beats <= 0;
        end else begin
            if (b_arvalid) b_ar_beats <= b_ar_beats + 1;
            if (b_arvalid) b_rvalid <= 1'b1;
            else if (b_rvalid && b_rready) b_rvalid <= 1'b0;
        end
    end

    // Register-slave model for the main instance.
    int          aw_delay, w_delay, ar_delay;
    logic [1:0]  b_resp_cfg, r_force_resp;
    logic        r_force;
    logic [31:0] r_force_data;
    int          aw_wait, w_wait, ar_wait, matw_cnt, cyc;
    logic        got_aw, got_w, r_wait, matw;
    logic [31:0] aw_lat, wd_lat, r_addr, wr_addr, wr_data;
    logic        aw_hs, w_hs, ar_hs;

    assign awready = awvalid && (aw_wait == aw_delay);
    assign wready  = wvalid && (w_wait == w_delay);
    assign arready = arvalid && (ar_wait == ar_delay);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign wr_addr = aw_hs ? awaddr : aw_lat;
    assign wr_data = w_hs ? wdata : wd_lat;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; matw_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; r_wait <= 1'b0; matw <= 1'b0;
            aw_lat <= 32'd0; wd_lat <= 32'd0; r_addr <= 32'd0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= 32'd0; rresp <= 2'b00;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (matw_cnt != 0) begin
                matw_cnt <= matw_cnt - 1;
                if (matw_cnt == 1) matw <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                bvalid <= 1'b1;
                bresp  <= b_resp_cfg;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                if (wr_addr == 32'd0) begin
                    matw     <= wr_data[0];
                    matw_cnt <= wr_data[0] ? 100 : 0;
                end
            end else begin
                if (aw_hs) begin got_aw <= 1'b1; aw_lat <= awaddr; end
                if (w_hs) begin got_w <= 1'b1; wd_lat <= wdata; end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (ar_hs) begin
                r_wait <= 1'b1;
                r_addr <= araddr;
            end else if (r_wait) begin
                r_wait <= 1'b0;
                rvalid <= 1'b1;
                rdata  <= r_force ? r_force_data
                        : (r_addr == 32'd0) ? {31'd0, matw} : (32'hA5A5_0000 | r_addr);
                rresp  <= r_force ? r_force_resp : 2'b00;
            end
        end
    end

    // Handshake statistics, cleared on request from the stimulus.
    logic        clr_stats;
    int          aw_beats, w_beats, ar_beats, b_beats, awv_cycles, wv_cycles;
    int          acc_cyc, aw_hs_cyc, w_hs_cyc, bready_cyc, last_ar_cyc, min_ar_gap;
    logic [31:0] last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;

    always @(posedge clk) begin
        if (clr_stats) begin
            aw_beats <= 0; w_beats <= 0; ar_beats <= 0; b_beats <= 0;
            awv_cycles <= 0; wv_cycles <= 0; acc_cyc <= 0;
            aw_hs_cyc <= -1; w_hs_cyc <= -1; bready_cyc <= -1;
            last_ar_cyc <= -1; min_ar_gap <= 1000000;
            last_awaddr <= 32'hFFFF_FFFF; last_wdata <= 32'hFFFF_FFFF; last_wstrb <= 4'h0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc <= cyc;
            if (aw_hs) begin aw_beats <= aw_beats + 1; aw_hs_cyc <= cyc; last_awaddr <= awaddr; end
            if (w_hs) begin
                w_beats <= w_beats + 1; w_hs_cyc <= cyc;
                last_wdata <= wdata; last_wstrb <= wstrb;
            end
            if (bvalid && bready) b_beats <= b_beats + 1;
            if (bready && bready_cyc < 0) bready_cyc <= cyc;
            if (awvalid) awv_cycles <= awv_cycles + 1;
            if (wvalid) wv_cycles <= wv_cycles + 1;
            if (ar_hs) begin
                ar_beats <= ar_beats + 1;
                if (last_ar_cyc >= 0 && (cyc - last_ar_cyc) < min_ar_gap)
                    min_ar_gap <= cyc - last_ar_cyc;
                last_ar_cyc <= cyc;
            end
        end
    end

    int n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
    endtask

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] m);
        int n;
        cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) check("cmd_accept_timeout", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for the response, optionally holds rsp_ready low for `hold` cycles while checking
    // the held response against bp_rd/bp_pl, then completes the handshake.
    task automatic wait_rsp(input int hold, input logic [31:0] bp_rd, input logic [15:0] bp_pl,
                            output logic [31:0] rd, output logic er, output logic [15:0] pl,
                            output int lat);
        lat = 0; rd = 32'd0; er = 1'b0; pl = 16'd0;
        while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 1);
        end else begin
            rd = rsp_rdata; er = rsp_err; pl = rsp_polls;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bp_rdata", rsp_rdata, bp_rd);
                check("bp_polls", 32'(rsp_polls), 32'(bp_pl));
                check("bp_flags", 32'({rsp_valid, rsp_err, cmd_ready, awvalid | wvalid | arvalid}),
                      32'h8);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            check("post_rsp_ready", 32'({rsp_valid, cmd_ready}), 1);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    logic [15:0] pl;
    int          lat, n;

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; clr_stats = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_mask = 32'd0;
        rsp_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_op = 2'b00; b_cmd_addr = 32'd0; b_cmd_wdata = 32'd0;
        b_cmd_mask = 32'd0; b_rsp_ready = 1'b0;
        aw_delay = 0; w_delay = 0; ar_delay = 0; b_resp_cfg = 2'b00;
        r_force = 1'b0; r_force_data = 32'd0; r_force_resp = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 0);
        check("rst_rsp", 32'({rsp_err, rsp_polls}), 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", awaddr | wdata | araddr, 0);
        check("rst_wstrb", 32'(wstrb), 32'hF);
        rst_n = 1'b1;
        clr_stats = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 1);

        // Write 0x000 <- 0x1
        clear_stats();
        issue(2'b00, 32'h0, 32'h1, 32'h0);
        wait_rsp(0, 32'd0, 16'd0, rd, er, pl, lat);
        check("wr_latency", 32'(lat), 3);
        check("wr_rsp", rd, 0);
        check("wr_err_polls", 32'({er, pl}), 0);
        check("wr_beats", 32'(aw_beats * 16 + w_beats * 4 + b_beats), 32'h15);
        check("wr_awaddr", last_awaddr, 0);
        check("wr_wdata", last_wdata, 1);
        check("wr_wstrb", 32'(last_wstrb), 32'hF);
        check("wr_same_cycle", 32'(aw_hs_cyc - w_hs_cyc), 0);
        check("matw_set", 32'(matw), 1);

        // Poll 0x000 until matw self-clears
        clear_stats();
        issue(2'b10, 32'h0, 32'h0, 32'h1);
        wait_rsp(0, 32'd0, 16'd0, rd, er, pl, lat);
        check("poll_err", 32'(er), 0);
        check("poll_ge2", 32'(pl >= 16'd2), 1);
        check("poll_rdata_bit0", rd & 32'h1, 0);
        check("poll_ar_beats", 32'(ar_beats), 32'(pl));
        check("poll_ar_spacing", 32'(min_ar_gap >= 6), 1);

        // Split AW/W with an error response; low address bits ignored
        aw_delay = 4; b_resp_cfg = 2'b10;
        clear_stats();
        issue(2'b00, 32'h13, 32'h5A, 32'h0);
        wait_rsp(0, 32'd0, 16'd0, rd, er, pl, lat);
        check("split_w_cycle", 32'(w_hs_cyc - acc_cyc), 1);
        check("split_aw_cycle", 32'(aw_hs_cyc - acc_cyc), 5);
        check("split_bready_cycle", 32'(bready_cyc - acc_cyc), 6);
        check("split_valid_cycles", 32'(awv_cycles * 16 + wv_cycles), 32'h51);
        check("split_awaddr", last_awaddr, 32'h10);
        check("split_b_beats", 32'(b_beats), 1);
        check("split_latency", 32'(lat), 7);
        check("split_rsp", 32'({er, pl}), 32'h10000);
        aw_delay = 0; b_resp_cfg = 2'b00;

        // Read with SLVERR
        r_force = 1'b1; r_force_data = 32'hDEAD_BEEF; r_force_resp = 2'b10;
        issue(2'b01, 32'h8, 32'h0, 32'h0);
        wait_rsp(0, 32'd0, 16'd0, rd, er, pl, lat);
        r_force = 1'b0;
        check("rderr_rdata", rd, 32'hDEAD_BEEF);
        check("rderr_err_polls", 32'({er, pl}), 32'h10001);
        check("rderr_latency", 32'(lat), 4);

        // Reserved op behaves as read
        clear_stats();
        issue(2'b11, 32'h20, 32'h0, 32'h0);
        wait_rsp(0, 32'd0, 16'd0, rd, er, pl, lat);
        check("op11_rdata", rd, 32'hA5A5_0020);
        check("op11_err_polls", 32'({er, pl}), 1);
        check("op11_ar_beats", 32'(ar_beats), 1);

        // Response backpressure for 10 cycles
        issue(2'b01, 32'h4, 32'h0, 32'h0);
        wait_rsp(10, 32'hA5A5_0004, 16'd1, rd, er, pl, lat);
        check("bp_rdata_final", rd, 32'hA5A5_0004);

        // Reset while the slave stalls AR
        ar_delay = 1000;
        issue(2'b01, 32'h10, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("stall_arvalid", 32'(arvalid), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ctrl", 32'({arvalid, rready, rsp_valid, cmd_ready}), 0);
        check("midrst_rsp", 32'({rsp_err, rsp_polls}), 0);
        check("midrst_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1; ar_delay = 0;
        @(negedge clk);
        check("midrst_ready", 32'(cmd_ready), 1);
        issue(2'b01, 32'h10, 32'h0, 32'h0);
        wait_rsp(0, 32'd0, 16'd0, rd, er, pl, lat);
        check("midrst_read", rd, 32'hA5A5_0010);
        check("midrst_read_flags", 32'({er, pl}), 1);
        check("midrst_read_latency", 32'(lat), 4);

        // Poll against a constant mismatch on the POLL_MAX=3 instance
        b_cmd_op = 2'b10; b_cmd_addr = 32'h10; b_cmd_wdata = 32'h1; b_cmd_mask = 32'h1;
        b_cmd_valid = 1'b1;
        n = 0;
        while (!b_cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 b_cmd_valid = 1'b0;
        n = 0;
        while (!b_rsp_valid && n < 500) begin @(negedge clk); n++; end
        check("lim_valid", 32'(b_rsp_valid), 1);
        check("lim_err", 32'(b_rsp_err), 1);
        check("lim_polls", 32'(b_rsp_polls), 3);
        check("lim_ar_beats", 32'(b_ar_beats), 3);
        check("lim_rdata", b_rsp_rdata, 0);
        b_rsp_ready = 1'b1;
        @(posedge clk);
        #1 b_rsp_ready = 1'b0;
        @(negedge clk);
        check("lim_post", 32'({b_rsp_valid, b_cmd_ready}), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
